// File: rtl/fp32_dot_sequencer.sv
// Sequences a shared FP32 MAC unit over a stream of (a, b) pairs and emits
// the accumulated dot product. Operand and result bits pass through untouched.
module fp32_dot_sequencer #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic             CLK_I,
  input  logic             RSTL_I,
  input  logic             IN_VALID_I,
  output logic             IN_READY_O,
  input  logic [31:0]      IN_A_I,
  input  logic [31:0]      IN_B_I,
  input  logic             IN_LAST_I,
  output logic             MAC_VALID_O,
  input  logic             MAC_READY_I,
  output logic [31:0]      MAC_ALPHA_O,
  output logic [31:0]      MAC_BRAVO_O,
  output logic [31:0]      MAC_ACC_O,
  input  logic             MAC_VALID_I,
  output logic             MAC_READY_O,
  input  logic [31:0]      MAC_DELTA_I,
  output logic             OUT_VALID_O,
  input  logic             OUT_READY_I,
  output logic [31:0]      OUT_DATA_O,
  output logic [CNT_W-1:0] OUT_COUNT_O,
  output logic             OUT_OVF_O
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case leaves one unassigned (which would infer a latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    last_d  = last_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID_I && in_ready_q) begin
          a_d     = IN_A_I;
          b_d     = IN_B_I;
          last_d  = IN_LAST_I;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (MAC_READY_I) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (MAC_VALID_I) begin
          acc_d   = MAC_DELTA_I;
          count_d = count_inc;
          // Truncation closes the vector early; remaining pairs start a new one.
          if (last_q || (count_inc == CNT_W'(MAX_LEN))) begin
            ovf_d   = ~last_q;
            state_d = S_EMIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (OUT_READY_I) begin
          acc_d   = 32'h0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase

    // Registered so that IN_READY_O stays low while reset is held.
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q    <= S_IDLE;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      acc_q      <= 32'h0;
      count_q    <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign IN_READY_O  = in_ready_q;
  assign MAC_VALID_O = (state_q == S_ISSUE);
  assign MAC_ALPHA_O = a_q;
  assign MAC_BRAVO_O = b_q;
  assign MAC_ACC_O   = acc_q;
  assign MAC_READY_O = (state_q == S_WAIT);
  assign OUT_VALID_O = (state_q == S_EMIT);
  assign OUT_DATA_O  = acc_q;
  assign OUT_COUNT_O = count_q;
  assign OUT_OVF_O   = ovf_q;

endmodule

// File: tb/tb_fp32_dot_sequencer.sv
// Directed bench for fp32_dot_sequencer: a behavioural MAC responder and a
// result sink compare DUT traffic against scoreboard queues filled by the stimulus.
module tb_fp32_dot_sequencer;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [31:0]      in_a_i = '0;
  logic [31:0]      in_b_i = '0;
  logic             in_last_i = 1'b0;
  logic             mac_valid_o;
  logic             mac_ready_i;
  logic [31:0]      mac_alpha_o;
  logic [31:0]      mac_bravo_o;
  logic [31:0]      mac_acc_o;
  logic             mac_valid_i;
  logic             mac_ready_o;
  logic [31:0]      mac_delta_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_data_o;
  logic [CNT_W-1:0] out_count_o;
  logic             out_ovf_o;

  always #5 clk = ~clk;

  fp32_dot_sequencer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .CLK_I(clk), .RSTL_I(rst_n),
    .IN_VALID_I(in_valid_i), .IN_READY_O(in_ready_o),
    .IN_A_I(in_a_i), .IN_B_I(in_b_i), .IN_LAST_I(in_last_i),
    .MAC_VALID_O(mac_valid_o), .MAC_READY_I(mac_ready_i),
    .MAC_ALPHA_O(mac_alpha_o), .MAC_BRAVO_O(mac_bravo_o), .MAC_ACC_O(mac_acc_o),
    .MAC_VALID_I(mac_valid_i), .MAC_READY_O(mac_ready_o), .MAC_DELTA_I(mac_delta_i),
    .OUT_VALID_O(out_valid_o), .OUT_READY_I(out_ready_i),
    .OUT_DATA_O(out_data_o), .OUT_COUNT_O(out_count_o), .OUT_OVF_O(out_ovf_o)
  );

  typedef struct {
    logic [31:0] a, b, acc, res;
    logic        ends;
  } mac_exp_t;

  typedef struct {
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } out_exp_t;

  mac_exp_t    mac_q[$];
  out_exp_t    out_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mac_stall = 0;
  int          mac_lat = 1;
  int          out_stall = 0;
  int          results_seen = 0;
  int          results_expected = 0;
  logic        mac_presenting = 1'b0;
  logic [31:0] acc_model = 32'h0;
  int          cnt_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact for the normal, short-mantissa values used here; denormals read as zero.
  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
    mac_exp_t me;
    out_exp_t oe;
    int       guard = 0;
    me.a   = a;
    me.b   = b;
    me.acc = acc_model;
    acc_model = r2f(f2r(a) * f2r(b) + f2r(acc_model));
    me.res = acc_model;
    cnt_model++;
    me.ends = last || (cnt_model == MAX_LEN);
    mac_q.push_back(me);
    if (me.ends) begin
      oe.data = acc_model;
      oe.cnt  = CNT_W'(cnt_model);
      oe.ovf  = ~last;
      out_q.push_back(oe);
      results_expected++;
      acc_model = 32'h0;
      cnt_model = 0;
    end
    @(negedge clk);
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = b;
    in_last_i  = last;
    while (!in_ready_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("in_handshake", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((out_q.size() != 0 || mac_q.size() != 0 || out_valid_o || mac_valid_o || mac_ready_o)
           && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_idle", 32'(out_q.size() + mac_q.size()), 32'd0);
  endtask

  // MAC responder: checks each request against the scoreboard, then returns its result.
  initial begin : mac_model
    mac_exp_t e;
    int       guard;
    mac_ready_i = 1'b0;
    mac_valid_i = 1'b0;
    mac_delta_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && mac_valid_o) begin
        check("mac_req_expected", 32'(mac_q.size() != 0), 32'd1);
        if (mac_q.size() != 0) e = mac_q.pop_front();
        for (int s = 0; s <= mac_stall; s++) begin
          check("mac_alpha", mac_alpha_o, e.a);
          check("mac_bravo", mac_bravo_o, e.b);
          check("mac_acc", mac_acc_o, e.acc);
          check("mac_valid_held", 32'(mac_valid_o), 32'd1);
          check("in_ready_busy", 32'(in_ready_o), 32'd0);
          if (s == mac_stall) mac_ready_i = 1'b1;
          @(negedge clk);
        end
        mac_ready_i = 1'b0;
        repeat (mac_lat) @(negedge clk);
        mac_valid_i    = 1'b1;
        mac_delta_i    = e.res;
        mac_presenting = 1'b1;
        guard = 0;
        while (rst_n && !mac_ready_o && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        if (rst_n) @(negedge clk);
        mac_valid_i    = 1'b0;
        mac_presenting = 1'b0;
        if (rst_n) begin
          if (e.ends) check("out_valid_after_mac", 32'(out_valid_o), 32'd1);
          else        check("in_ready_after_mac", 32'(in_ready_o), 32'd1);
        end
      end
    end
  end

  // Result sink: optional backpressure, stability and value checks.
  initial begin : out_sink
    out_exp_t e;
    out_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_o) begin
        check("out_expected", 32'(out_q.size() != 0), 32'd1);
        if (out_q.size() != 0) e = out_q.pop_front();
        for (int s = 0; s <= out_stall; s++) begin
          check("out_data", out_data_o, e.data);
          check("out_count", 32'(out_count_o), 32'(e.cnt));
          check("out_ovf", 32'(out_ovf_o), 32'(e.ovf));
          check("out_valid_held", 32'(out_valid_o), 32'd1);
          check("emit_in_ready", 32'(in_ready_o), 32'd0);
          check("emit_mac_idle", 32'({mac_valid_o, mac_ready_o}), 32'd0);
          if (s == out_stall) out_ready_i = 1'b1;
          @(negedge clk);
        end
        out_ready_i = 1'b0;
        results_seen++;
      end
    end
  end

  initial begin : stimulus
    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_valids", 32'({mac_valid_o, mac_ready_o, out_valid_o}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready_o), 32'd1);

    // Single pair 2.0*2.0
    send_pair(32'h40000000, 32'h40000000, 1'b1);
    drain();

    // 1*3 + 2*4 = 11.0
    send_pair(32'h3F800000, 32'h40400000, 1'b0);
    send_pair(32'h40000000, 32'h40800000, 1'b1);
    drain();

    // Backpressure on both MAC request and result output
    mac_stall = 5;
    out_stall = 4;
    send_pair(32'h40400000, 32'h3F000000, 1'b1);
    drain();
    mac_stall = 0;
    out_stall = 0;

    // Back-to-back vectors; the second must start from +0.0
    send_pair(32'h40000000, 32'h40400000, 1'b1);
    send_pair(32'h3F800000, 32'h40000000, 1'b1);
    drain();

    // Truncation at MAX_LEN, then the leftover pair forms its own vector
    for (int i = 0; i < 5; i++) send_pair(32'h3F800000, 32'h3F800000, (i == 4));
    drain();

    // Reset while in WAIT with a MAC result on the bus
    mac_lat = 3;
    send_pair(32'h40000000, 32'h40000000, 1'b1);
    for (int i = 0; i < 400 && !mac_presenting; i++) #1;
    check("rst_mid_in_wait", 32'({mac_presenting, mac_ready_o}), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valids", 32'({mac_valid_o, mac_ready_o, out_valid_o}), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    out_q.delete();
    mac_q.delete();
    results_expected--;
    acc_model = 32'h0;
    cnt_model = 0;
    mac_lat   = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_in_ready", 32'(in_ready_o), 32'd1);
    send_pair(32'h40000000, 32'h40000000, 1'b1);
    drain();

    check("result_count", 32'(results_seen), 32'(results_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_dot_sequencer.md
Name: fp32_dot_sequencer

Overview:
- Controller that sequences the shared FP32 MAC unit to compute dot products of arbitrary-length operand streams.
- Accepts (a, b) FP32 pairs with a LAST marker over a valid/ready stream. Issues one MAC operation per pair with the running accumulator fed back as the acc operand, and emits the final sum on a valid/ready output.
- Sits between the UART receive front end and UART transmit back end, in place of the direct single-shot MAC hookup.

Parameters:
- MAX_LEN, 256, maximum pairs per dot product before forced termination (power of 2 not required, >=1).
- CNT_W, 9, width of element counter; must hold MAX_LEN.

Ports:
- CLK_I  in  1  clock, rising edge.
- RSTL_I  in  1  asynchronous active-low reset.
- IN_VALID_I  in  1  operand pair valid.
- IN_READY_O  out  1  sequencer can accept a pair.
- IN_A_I  in  32  FP32 operand a.
- IN_B_I  in  32  FP32 operand b.
- IN_LAST_I  in  1  pair is the final element of the vector.
- MAC_VALID_O  out  1  MAC request valid.
- MAC_READY_I  in  1  MAC accepts request.
- MAC_ALPHA_O  out  32  MAC multiplicand a.
- MAC_BRAVO_O  out  32  MAC multiplicand b.
- MAC_ACC_O  out  32  MAC addend (running sum).
- MAC_VALID_I  in  1  MAC result valid.
- MAC_READY_O  out  1  sequencer accepts MAC result.
- MAC_DELTA_I  in  32  MAC result a*b+acc.
- OUT_VALID_O  out  1  dot product valid.
- OUT_READY_I  in  1  downstream accepts result.
- OUT_DATA_O  out  32  FP32 dot product.
- OUT_COUNT_O  out  CNT_W  number of pairs accumulated.
- OUT_OVF_O  out  1  vector was truncated at MAX_LEN.

Behaviour:
- Clock/reset: one clock CLK_I. RSTL_I is asynchronous, active-low.
- Reset values:
  - state=IDLE, acc_reg=32'h0, count=0, ovf=0, operand regs=0.
  - MAC_VALID_O=0, MAC_READY_O=0, OUT_VALID_O=0, IN_READY_O=0 while RSTL_I low; IN_READY_O=1 from the first cycle after reset release.
- Handshakes: a transfer occurs on a rising edge with valid&ready high. Valid, once asserted, holds with stable data until accepted. Ready never depends combinationally on the same interface's valid.
- FSM states:
  - IDLE: IN_READY_O=1. On input handshake, latch a, b, last into regs → ISSUE.
  - ISSUE: MAC_VALID_O=1; ALPHA/BRAVO=latched a/b, ACC=acc_reg. On MAC_READY_I → WAIT. Hold everything stable otherwise.
  - WAIT: MAC_READY_O=1. On MAC_VALID_I: acc_reg<=MAC_DELTA_I, count<=count+1.
    - If last_reg=1 or count+1==MAX_LEN → EMIT; set ovf<=1 only when last_reg=0.
    - Otherwise → IDLE.
  - EMIT: OUT_VALID_O=1, OUT_DATA_O=acc_reg, OUT_COUNT_O=count, OUT_OVF_O=ovf. On OUT_READY_I: acc_reg<=0, count<=0, ovf<=0 → IDLE.
- Throughput and latency:
  - One MAC operation in flight at a time; no overlap between requests.
  - Minimum per-pair cost is 3 cycles plus MAC latency.
  - Result is valid 1 cycle after the final MAC result handshake.
- Output stability: OUT_* and MAC_* outputs are registered or decoded from state plus registers only. No combinational path from any input to any output.
- Overflow:
  - After truncation, subsequent pairs up to and including the LAST pair form a new vector. No silent dropping.
  - OUT_OVF_O flags the truncated result.
- MAC result without request: MAC_VALID_I outside WAIT is ignored (MAC_READY_O=0).
- Floating point: the sequencer performs no arithmetic on operand or result values; it passes them through bit-exact. Initial acc is +0.0 (32'h00000000).
- Reset mid-operation: any state returns to IDLE immediately. A pending MAC result and the partial sum are discarded. Outputs take reset values asynchronously.

Test Plan:
- Single pair a=40000000 (2.0), b=40000000, LAST=1 → MAC sees ACC=00000000; OUT_DATA_O=40800000 (4.0), COUNT=1, OVF=0.
- Vector [3F800000, 40000000]·[40400000, 40800000] (1·3 + 2·4), LAST on 2nd → second MAC request has ACC=40400000; OUT_DATA_O=41300000 (11.0), COUNT=2.
- Backpressure: MAC_READY_I low 5 cycles in ISSUE, then OUT_READY_I low 4 cycles in EMIT → ALPHA/BRAVO/ACC and OUT_DATA_O stable throughout; IN_READY_O=0 throughout; single result emitted.
- Back-to-back vectors: second vector starts right after the first result handshake → second result starts from acc=0, independent of the first sum.
- MAX_LEN=4, five pairs of 1.0·1.0 with LAST on the 5th → first result 40800000 (4.0), COUNT=4, OVF=1; second result 3F800000, COUNT=1, OVF=0.
- Assert RSTL_I low while in WAIT, with a MAC result arriving the same cycle → all valids drop immediately. After release, a 1-pair vector 2.0·2.0 yields 40800000, proving the accumulator was cleared.
